// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared types and constants for the RV32M multiply/divide sequencer.
//   muldiv_op_e    : funct3 encoding of the M-extension operations
//   muldiv_state_e : sequencer FSM states
//   ALU_ADD/ALU_SUB: control codes driven onto the shared EX ALU
//   FLAG_C         : position of the carry bit in the ALU flag vector {v,c,n,z}
package muldiv_pkg;

   localparam int XLEN     = 32;
   localparam int ITER_CNT = 32;

   typedef enum logic [2:0] {
      OP_MUL    = 3'd0,
      OP_MULH   = 3'd1,
      OP_MULHSU = 3'd2,
      OP_MULHU  = 3'd3,
      OP_DIV    = 3'd4,
      OP_DIVU   = 3'd5,
      OP_REM    = 3'd6,
      OP_REMU   = 3'd7
   } muldiv_op_e;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_PREP  = 3'd1,
      ST_ITER  = 3'd2,
      ST_FIXUP = 3'd3,
      ST_DONE  = 3'd4
   } muldiv_state_e;

   localparam logic [3:0] ALU_ADD = 4'b0000;
   localparam logic [3:0] ALU_SUB = 4'b0001;
   localparam int         FLAG_C  = 2;

   // Divide/remainder ops occupy the upper half of the funct3 space.
   function automatic logic op_is_div(input muldiv_op_e op);
      return (op == OP_DIV) || (op == OP_DIVU) || (op == OP_REM) || (op == OP_REMU);
   endfunction

endpackage

// File: rtl/muldiv_sign_fix.sv
// muldiv_sign_fix: combinational sign conditioning.
//   val32_i/neg32_i -> val32_o : 32-bit conditional negate (magnitude when neg32_i is the sign)
//   val64_i/neg64_i -> val64_o : 64-bit conditional two's-complement negate
// The low word of a 64-bit negate equals the 32-bit negate of the low word,
// which lets one instance condition two independent 32-bit quantities.
module muldiv_sign_fix
   import muldiv_pkg::*;
#(
   parameter int W = XLEN
) (
   input  logic [W-1:0]   val32_i,
   input  logic           neg32_i,
   output logic [W-1:0]   val32_o,
   input  logic [2*W-1:0] val64_i,
   input  logic           neg64_i,
   output logic [2*W-1:0] val64_o
);

   assign val32_o = neg32_i ? -val32_i : val32_i;
   assign val64_o = neg64_i ? -val64_i : val64_i;

endmodule

// File: rtl/muldiv_seq.sv
// muldiv_seq: multi-cycle RV32M multiply/divide sequencer living in EX.
// Shift-add multiply and restoring divide, one add/sub per iteration on the
// shared EX ALU. Holds busy_o high while an op is in flight and retires the
// result with a one-cycle done_o pulse.
//   clk, rst_n                 : clock, synchronous active-low reset
//   start_i, op_i, rs1_i, rs2_i: launch request and operands (sampled in IDLE)
//   flush_i                    : abort the op in flight
//   busy_o, done_o, result_o   : pipeline stall, completion pulse, result
//   alu_sel_o, alu_a_o, alu_b_o, alu_ctrl_o, alu_result_i, alu_flags_i: shared ALU
module muldiv_seq
   import muldiv_pkg::*;
#(
   parameter int XLEN_P   = XLEN,
   parameter int ITER_N   = ITER_CNT
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start_i,
   input  logic [2:0]        op_i,
   input  logic [XLEN_P-1:0] rs1_i,
   input  logic [XLEN_P-1:0] rs2_i,
   input  logic              flush_i,
   output logic              busy_o,
   output logic              done_o,
   output logic [XLEN_P-1:0] result_o,
   output logic              alu_sel_o,
   output logic [XLEN_P-1:0] alu_a_o,
   output logic [XLEN_P-1:0] alu_b_o,
   output logic [3:0]        alu_ctrl_o,
   input  logic [XLEN_P-1:0] alu_result_i,
   input  logic [3:0]        alu_flags_i
);

   localparam int                CW       = $clog2(ITER_N);
   localparam logic [CW-1:0]     CNT_LAST = CW'(ITER_N - 1);
   localparam logic [XLEN_P-1:0] MIN_NEG  = {1'b1, {(XLEN_P-1){1'b0}}};
   localparam logic [XLEN_P-1:0] ALL_ONES = '1;

   muldiv_state_e     state_q, state_d;
   muldiv_op_e        op_q, op_d;
   logic [XLEN_P-1:0] a_q, a_d, b_q, b_d;       // raw operands
   logic [XLEN_P-1:0] hi_q, hi_d, lo_q, lo_d;   // product {hi,lo} or {R,Q}
   logic [XLEN_P-1:0] opnd_q, opnd_d;           // multiplicand or divisor magnitude
   logic [XLEN_P-1:0] result_q, result_d;
   logic              sa_q, sa_d, sb_q, sb_d;
   logic              div0_q, div0_d, ovf_q, ovf_d;
   logic [CW-1:0]     cnt_q, cnt_d;

   // Operand decode on the captured op.
   logic is_div, sa_w, sb_w;
   assign is_div = op_is_div(op_q);
   assign sa_w   = a_q[XLEN_P-1] & (op_q inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM});
   assign sb_w   = b_q[XLEN_P-1] & (op_q inside {OP_MULH, OP_DIV, OP_REM});

   // PREP conditioning: rs1 through the 32-bit path, rs2 through the low word
   // of the 64-bit path.
   logic [XLEN_P-1:0]   a_mag, b_mag;
   logic [2*XLEN_P-1:0] prep_wide;
   muldiv_sign_fix #(.W(XLEN_P)) u_prep_fix (
      .val32_i (a_q),
      .neg32_i (sa_w),
      .val32_o (a_mag),
      .val64_i ({{XLEN_P{1'b0}}, b_q}),
      .neg64_i (sb_w),
      .val64_o (prep_wide)
   );
   assign b_mag = prep_wide[XLEN_P-1:0];

   // FIXUP conditioning: 64-bit path negates the product (its low word doubles
   // as the signed quotient); 32-bit path gives the signed remainder.
   logic [XLEN_P-1:0]   rem_fix;
   logic [2*XLEN_P-1:0] prod_fix;
   muldiv_sign_fix #(.W(XLEN_P)) u_fixup_fix (
      .val32_i (hi_q),
      .neg32_i (sa_q),
      .val32_o (rem_fix),
      .val64_i ({hi_q, lo_q}),
      .neg64_i (sa_q ^ sb_q),
      .val64_o (prod_fix)
   );

   // Restoring-divide step: shift Q's MSB into R; the bit shifted out of R
   // (rbit) forces acceptance because the 33-bit remainder then exceeds the divisor.
   logic [XLEN_P-1:0] r_shift;
   logic              alu_c, accept;
   assign r_shift = {hi_q[XLEN_P-2:0], lo_q[XLEN_P-1]};
   assign alu_c   = alu_flags_i[FLAG_C];
   assign accept  = hi_q[XLEN_P-1] | alu_c;

   // Only the carry flag matters here; the high half of the PREP negate is don't-care.
   logic unused_ok;
   assign unused_ok = ^{alu_flags_i[3], alu_flags_i[1:0], prep_wide[2*XLEN_P-1:XLEN_P]};

   always_comb begin
      state_d    = state_q;
      op_d       = op_q;
      a_d        = a_q;
      b_d        = b_q;
      hi_d       = hi_q;
      lo_d       = lo_q;
      opnd_d     = opnd_q;
      result_d   = result_q;
      sa_d       = sa_q;
      sb_d       = sb_q;
      div0_d     = div0_q;
      ovf_d      = ovf_q;
      cnt_d      = cnt_q;
      alu_sel_o  = 1'b0;
      alu_a_o    = '0;
      alu_b_o    = '0;
      alu_ctrl_o = ALU_ADD;

      case (state_q)
         ST_IDLE: begin
            if (start_i) begin
               op_d    = muldiv_op_e'(op_i);
               a_d     = rs1_i;
               b_d     = rs2_i;
               state_d = ST_PREP;
            end
         end
         ST_PREP: begin
            sa_d    = sa_w;
            sb_d    = sb_w;
            hi_d    = '0;
            lo_d    = is_div ? a_mag : b_mag;
            opnd_d  = is_div ? b_mag : a_mag;
            div0_d  = is_div && (b_q == '0);
            ovf_d   = (op_q inside {OP_DIV, OP_REM}) && (a_q == MIN_NEG) && (b_q == ALL_ONES);
            cnt_d   = '0;
            state_d = (div0_d || ovf_d) ? ST_FIXUP : ST_ITER;
         end
         ST_ITER: begin
            alu_sel_o = 1'b1;
            alu_b_o   = opnd_q;
            if (is_div) begin
               alu_a_o    = r_shift;
               alu_ctrl_o = ALU_SUB;
               hi_d       = accept ? alu_result_i : r_shift;
               lo_d       = {lo_q[XLEN_P-2:0], accept};
            end else begin
               alu_a_o = hi_q;
               if (!lo_q[0]) alu_b_o = '0;
               // {c,hi,lo} >> 1 after adding the (possibly gated) multiplicand.
               hi_d = {alu_c, alu_result_i[XLEN_P-1:1]};
               lo_d = {alu_result_i[0], lo_q[XLEN_P-1:1]};
            end
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == CNT_LAST) state_d = ST_FIXUP;
         end
         ST_FIXUP: begin
            case (op_q)
               OP_MUL:                        result_d = prod_fix[XLEN_P-1:0];
               OP_MULH, OP_MULHSU, OP_MULHU:  result_d = prod_fix[2*XLEN_P-1:XLEN_P];
               OP_DIV, OP_DIVU:
                  result_d = div0_q ? ALL_ONES : (ovf_q ? MIN_NEG : prod_fix[XLEN_P-1:0]);
               default:
                  result_d = div0_q ? a_q : (ovf_q ? '0 : rem_fix);
            endcase
            state_d = ST_DONE;
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase

      // Abort from any state; the previous result stays visible.
      if (flush_i) begin
         state_d  = ST_IDLE;
         result_d = result_q;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q  <= ST_IDLE;
         op_q     <= OP_MUL;
         a_q      <= '0;
         b_q      <= '0;
         hi_q     <= '0;
         lo_q     <= '0;
         opnd_q   <= '0;
         result_q <= '0;
         sa_q     <= 1'b0;
         sb_q     <= 1'b0;
         div0_q   <= 1'b0;
         ovf_q    <= 1'b0;
         cnt_q    <= '0;
      end else begin
         state_q  <= state_d;
         op_q     <= op_d;
         a_q      <= a_d;
         b_q      <= b_d;
         hi_q     <= hi_d;
         lo_q     <= lo_d;
         opnd_q   <= opnd_d;
         result_q <= result_d;
         sa_q     <= sa_d;
         sb_q     <= sb_d;
         div0_q   <= div0_d;
         ovf_q    <= ovf_d;
         cnt_q    <= cnt_d;
      end
   end

   assign busy_o   = state_q inside {ST_PREP, ST_ITER, ST_FIXUP};
   assign done_o   = (state_q == ST_DONE);
   assign result_o = result_q;

endmodule

// File: tb/tb_muldiv_seq.sv
// tb_muldiv_seq: directed testbench for muldiv_seq with a behavioural model
// of the shared EX ALU (add/sub with carry flag).
module tb_muldiv_seq;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start_i;
   logic [2:0]  op_i;
   logic [31:0] rs1_i, rs2_i;
   logic        flush_i;
   logic        busy_o, done_o, alu_sel_o;
   logic [31:0] result_o, alu_a_o, alu_b_o, alu_result_i;
   logic [3:0]  alu_ctrl_o, alu_flags_i;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   muldiv_seq dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .start_i      (start_i),
      .op_i         (op_i),
      .rs1_i        (rs1_i),
      .rs2_i        (rs2_i),
      .flush_i      (flush_i),
      .busy_o       (busy_o),
      .done_o       (done_o),
      .result_o     (result_o),
      .alu_sel_o    (alu_sel_o),
      .alu_a_o      (alu_a_o),
      .alu_b_o      (alu_b_o),
      .alu_ctrl_o   (alu_ctrl_o),
      .alu_result_i (alu_result_i),
      .alu_flags_i  (alu_flags_i)
   );

   // EX ALU model: sub computes a + ~b + 1, so carry means "no borrow".
   logic [32:0] alu_sum;
   always_comb begin
      alu_sum = '0;
      if (alu_ctrl_o == 4'b0001) alu_sum = {1'b0, alu_a_o} + {1'b0, ~alu_b_o} + 33'd1;
      else                       alu_sum = {1'b0, alu_a_o} + {1'b0, alu_b_o};
   end
   assign alu_result_i = alu_sum[31:0];
   assign alu_flags_i  = {1'b0, alu_sum[32], alu_sum[31], alu_sum[31:0] == 32'd0};

   task automatic chk(input logic [31:0] obs, input logic [31:0] exp, input string tag);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $display("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
         $error("check %s", tag);
      end
   endtask

   // Launch one op, follow it to done_o and check latency, result and ALU use.
   // exp_cyc counts cycles from the accepting edge T (done in cycle T+exp_cyc).
   task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input int exp_cyc, input logic [31:0] exp_res, input string tag);
      int lat, sel_cnt, exp_sel;
      bit seen;
      logic [3:0] first_ctrl;
      exp_sel = (exp_cyc == 35) ? 32 : 0;
      @(negedge clk);
      start_i = 1'b1; op_i = op; rs1_i = a; rs2_i = b;
      @(posedge clk);
      #1;
      start_i = 1'b0;
      chk({31'd0, busy_o}, 32'd1, {tag, "_busy"});
      lat = 0; sel_cnt = 0; seen = 0; first_ctrl = 4'hF;
      while (!seen && lat < 60) begin
         @(posedge clk);
         #1;
         lat++;
         if (done_o) seen = 1;
         else if (alu_sel_o) begin
            if (sel_cnt == 0) first_ctrl = alu_ctrl_o;
            sel_cnt++;
         end
      end
      chk(lat + 1, exp_cyc, {tag, "_latency"});
      chk(result_o, exp_res, {tag, "_result"});
      chk({31'd0, busy_o}, 32'd0, {tag, "_busy_in_done"});
      chk(sel_cnt, exp_sel, {tag, "_alu_sel_cycles"});
      if (exp_sel > 0) chk({28'd0, first_ctrl}, {31'd0, op[2]}, {tag, "_alu_ctrl"});
      $display("op=%0d a=0x%08h b=0x%08h -> result=0x%08h cycles=%0d (%s)",
               op, a, b, result_o, lat + 1, tag);
      @(posedge clk);
      #1;
      chk({31'd0, done_o}, 32'd0, {tag, "_done_one_cycle"});
   endtask

   // Start a DIV and abort it at iteration count 10 by flush or reset.
   task automatic abort_op(input bit use_reset, input logic [31:0] exp_res, input string tag);
      int dones;
      @(negedge clk);
      start_i = 1'b1; op_i = 3'd4; rs1_i = 32'd100; rs2_i = 32'd7;
      @(posedge clk);
      #1;
      start_i = 1'b0;
      repeat (11) @(posedge clk);
      #1;
      chk({31'd0, alu_sel_o}, 32'd1, {tag, "_in_iter"});
      if (use_reset) rst_n = 1'b0; else flush_i = 1'b1;
      @(posedge clk);
      #1;
      rst_n = 1'b1; flush_i = 1'b0;
      chk({31'd0, busy_o}, 32'd0, {tag, "_busy_cleared"});
      chk({31'd0, alu_sel_o}, 32'd0, {tag, "_alu_sel_cleared"});
      chk(result_o, exp_res, {tag, "_result_after_abort"});
      dones = 0;
      repeat (40) begin
         @(posedge clk);
         #1;
         if (done_o) dones++;
      end
      chk(dones, 0, {tag, "_no_done"});
      $display("abort via %s at iteration 10, done pulses=%0d", use_reset ? "reset" : "flush", dones);
   endtask

   initial begin
      int dones, lat;
      rst_n = 1'b0; start_i = 1'b0; flush_i = 1'b0;
      op_i = 3'd0; rs1_i = '0; rs2_i = '0;
      repeat (3) @(posedge clk);
      #1;
      chk({31'd0, busy_o}, 32'd0, "reset_busy");
      chk({31'd0, done_o}, 32'd0, "reset_done");
      chk({31'd0, alu_sel_o}, 32'd0, "reset_alu_sel");
      chk(result_o, 32'd0, "reset_result");
      chk(alu_a_o | alu_b_o | {28'd0, alu_ctrl_o}, 32'd0, "reset_alu_operands");
      @(negedge clk);
      rst_n = 1'b1;

      run_op(3'd0, 32'd7,        32'd6,        35, 32'h0000002A, "mul_7x6");
      run_op(3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 35, 32'h00000000, "mulh_m1");
      run_op(3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 35, 32'hFFFFFFFE, "mulhu_max");
      run_op(3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 35, 32'hFFFFFFFF, "mulhsu_m1");
      run_op(3'd0, 32'h80000000, 32'hFFFFFFFF, 35, 32'h80000000, "mul_min");
      run_op(3'd4, 32'hFFFFFFF9, 32'd2,        35, 32'hFFFFFFFD, "div_m7_2");
      run_op(3'd6, 32'hFFFFFFF9, 32'd2,        35, 32'hFFFFFFFF, "rem_m7_2");
      run_op(3'd5, 32'hFFFFFFFF, 32'd1,        35, 32'hFFFFFFFF, "divu_max_1");
      run_op(3'd7, 32'd100,      32'd7,        35, 32'd2,        "remu_100_7");
      run_op(3'd4, 32'h80000000, 32'hFFFFFFFF, 3,  32'h80000000, "div_ovf");
      run_op(3'd6, 32'h80000000, 32'hFFFFFFFF, 3,  32'h00000000, "rem_ovf");
      run_op(3'd5, 32'd5,        32'd0,        3,  32'hFFFFFFFF, "divu_by0");
      run_op(3'd6, 32'd5,        32'd0,        3,  32'd5,        "rem_by0");

      abort_op(1'b0, 32'd5, "flush");
      run_op(3'd4, 32'd9, 32'd3, 35, 32'd3, "div_9_3_after_flush");
      abort_op(1'b1, 32'd0, "reset");
      run_op(3'd4, 32'd9, 32'd3, 35, 32'd3, "div_9_3_after_reset");

      // start_i held through an op: one done_o, second op taken in the next IDLE.
      @(negedge clk);
      start_i = 1'b1; op_i = 3'd0; rs1_i = 32'd7; rs2_i = 32'd6;
      @(posedge clk);
      dones = 0;
      repeat (34) begin
         @(posedge clk);
         #1;
         if (done_o) dones++;
      end
      chk({31'd0, done_o}, 32'd1, "held_done_at_35");
      chk(result_o, 32'h2A, "held_first_result");
      rs1_i = 32'd3; rs2_i = 32'd5;
      @(posedge clk);
      #1;
      chk({31'd0, busy_o | done_o}, 32'd0, "held_idle_gap");
      @(posedge clk);
      #1;
      start_i = 1'b0;
      chk({31'd0, busy_o}, 32'd1, "held_second_accepted");
      lat = 0;
      while (!done_o && lat < 60) begin
         @(posedge clk);
         #1;
         lat++;
      end
      dones++;
      chk(dones, 2, "held_done_count");
      chk(result_o, 32'd15, "held_second_result");
      $display("held start: done pulses=%0d second result=0x%08h", dones, result_o);

      // flush and start together in IDLE: nothing launches.
      @(negedge clk);
      start_i = 1'b1; flush_i = 1'b1; op_i = 3'd5; rs1_i = 32'd8; rs2_i = 32'd2;
      @(posedge clk);
      #1;
      start_i = 1'b0; flush_i = 1'b0;
      chk({31'd0, busy_o}, 32'd0, "flush_start_no_launch");
      $display("flush+start in IDLE: busy=%0d", busy_o);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
